// File: rtl/seq_div_ctrl.sv
// Multi-cycle unsigned divider: radix-2 restoring, one quotient bit per clock,
// with start/busy/done handshake, divide-by-zero result and held outputs.
module seq_div_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH:0]   trial, dext;
    logic             ge;
    logic             accept;

    // Next-state, iteration datapath and output-register next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        dbz_d       = div_by_zero;
        accept      = 1'b0;
        trial       = {r_q, q_q[WIDTH-1]};
        dext        = {1'b0, d_q};
        ge          = (trial >= dext);

        case (state_q)
            IDLE: accept = start;
            RUN: begin
                r_d   = ge ? WIDTH'(trial - dext) : WIDTH'(trial);
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance is shared by IDLE and DONE so back-to-back issue has no bubble.
        if (accept) begin
            if (divisor != '0) begin
                d_d     = divisor;
                r_d     = '0;
                q_d     = dividend;
                cnt_d   = '0;
                state_d = RUN;
            end else begin
                state_d     = DONE;
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Self-checking bench for seq_div_ctrl: directed corner cases plus random
// operand pairs compared against plain-arithmetic division.
module tb_seq_div_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_div_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands with start for one edge (E0); returns #1 after E0.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen, and how many samples had busy high.
    task automatic wait_done(input int limit, output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < limit) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int edges, input int busy_cnt);
        logic [WIDTH-1:0] eq, er;
        if (b == 0) begin
            eq = '1;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        check({tag, " latency"}, 64'(edges), (b == 0) ? 64'd0 : 64'(LAT));
        check({tag, " busy cycles"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'(LAT));
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " div_by_zero"}, 64'(div_by_zero), (b == 0) ? 64'd1 : 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int e, bc;
        issue(a, b);
        wait_done(100, e, bc);
        check_result(tag, a, b, e, bc);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    int e, bc, stray;
    logic [WIDTH-1:0] ra, rb;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("100/7", 32'd100, 32'd7);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1);
        run_op("3/10", 32'd3, 32'd10);
        run_op("5/0", 32'd5, 32'd0);
        run_op("9/3", 32'd9, 32'd3);
        run_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("0/9", 32'd0, 32'd9);

        // start during RUN must be ignored
        issue(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, e, bc);
        check("ignored start latency", 64'(e), 64'(LAT - 10));
        check("ignored start quotient", 64'(quotient), 64'd14);
        check("ignored start remainder", 64'(remainder), 64'd2);
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) stray++;
        end
        check("no second done", 64'(stray), 64'd0);
        check("held quotient in idle", 64'(quotient), 64'd14);

        // reset mid-RUN aborts without done
        issue(32'd1000, 32'd3);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset quotient", 64'(quotient), 64'd0);
        check("mid reset remainder", 64'(remainder), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        check("aborted op silent", 64'(stray), 64'd0);
        run_op("1000/3", 32'd1000, 32'd3);

        // back-to-back issue on the DONE cycle
        issue(32'h8000_0000, 32'h10);
        wait_done(100, e, bc);
        check_result("b2b first", 32'h8000_0000, 32'h10, e, bc);
        issue(32'd17, 32'd4);
        check("b2b accepted busy", 64'(busy), 64'd1);
        check("b2b done cleared", 64'(done), 64'd0);
        wait_done(100, e, bc);
        check_result("b2b second", 32'd17, 32'd4, e, bc);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = ra;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            issue(ra, rb);
            wait_done(100, e, bc);
            check_result("random", ra, rb, e, bc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_div_ctrl.md
Name: seq_div_ctrl

Overview:
- Multi-cycle controller and datapath for unsigned 32-bit division: radix-2 restoring algorithm, one quotient bit per clock.
- Replaces the single-cycle combinational divider on the ALU divide path.
- The core stalls on `busy` and captures the result on `done`.
- Provides a start/busy/done handshake, an explicit divide-by-zero result, and result hold until the next operation.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only when accepted (see Behaviour).
- dividend  input  WIDTH  numerator; sampled on an accepted start.
- divisor  input  WIDTH  denominator; sampled on an accepted start.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse; result valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; high if the last operation had divisor==0.

Behaviour:

Reset:
- Async on `rst` high: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal regs=0.
- Reset mid-RUN aborts the operation. No `done` is produced for it.

States (registered): IDLE, RUN, DONE.
- **IDLE:** start=1 is accepted.
  - divisor!=0: latch operands; R=0, Q=dividend, cnt=0 → RUN.
  - divisor==0: → DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- **RUN:** each cycle:
  - T={R[WIDTH-1:0],Q[WIDTH-1]} (WIDTH+1 bits); D=divisor zero-extended to WIDTH+1.
  - If T≥D: R=T−D, new Q LSB=1. Else: R=T, new Q LSB=0. Q shifts left by one.
  - cnt increments. The cycle with cnt==WIDTH−1 performs the last iteration → DONE.
  - start is ignored; operands are not re-sampled.
- **DONE:**
  - done=1 for exactly this cycle; quotient/remainder/div_by_zero are valid.
  - Next state IDLE, unless start=1 this cycle: then the new operation is accepted exactly as in IDLE (back-to-back issue, no bubble).

Timing (start sampled at edge E0):
- Nonzero divisor: busy=1 from after E0 through after E(WIDTH−1); done=1 in the cycle after edge E(WIDTH).
- WIDTH=32: done appears 32 edges after the start edge.
- Zero divisor: done=1 in the cycle after E0; busy never asserts.

Outputs:
- quotient, remainder and div_by_zero update only on entry to DONE.
- They hold until the next DONE entry or reset, so they are stable in IDLE.
- div_by_zero clears on the next nonzero-divisor completion.
- Internal working regs are separate from the output regs.

Arithmetic:
- Strictly unsigned; R never exceeds divisor−1 between iterations.
- Remainder output = R[WIDTH-1:0]; quotient output = Q.

Corner cases:
- dividend<divisor → quotient 0, remainder=dividend.
- dividend==divisor → quotient 1, remainder 0.
- divisor==1 → quotient=dividend, remainder 0.
- Max operands: 0xFFFFFFFF/0xFFFFFFFF → 1, 0.

Simultaneous events:
- rst dominates everything.
- start coincident with done is accepted.
- start held continuously issues a new op on every DONE cycle.

Test Plan:
1. Start with dividend=100, divisor=7 → busy for 32 cycles; done pulses once at edge 32; quotient=14, remainder=2, div_by_zero=0.
2. Start with dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then dividend=3, divisor=10 → quotient=0, remainder=3.
3. Start with dividend=5, divisor=0 → done the cycle after the start edge, busy never high; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Then 9/3 → quotient=3, remainder=0, div_by_zero=0.
4. Start 100/7; at cycle 10 pulse start with 50/5 → ignored. Result is 14/2; a second done does not appear without a new start.
5. Start 1000/3; assert rst at cycle 15 → all outputs 0 immediately, state IDLE, no done. After release, 1000/3 → quotient=333, remainder=1.
6. Back-to-back: start 0x80000000/0x10 → done 0x08000000/0. Start held high in the DONE cycle with 17/4 → accepted; done 32 edges later with quotient=4, remainder=1. Random compare vs reference model: 1000 unsigned pairs including 0 divisors.
